// File: rtl/frame_trend_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_trend_stats_pkg
//  Description : Shared types and constants for the frame trend statistics
//                block: FSM state encoding, sample width, counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_trend_stats_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_ACC   = 1'b1
  } state_t;

  // Smallest width w with 2**w >= n; a counter of this width holds n-1.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_trend_stats_comparator_4.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_4
//  Description : 4-bit unsigned magnitude comparator.
//                y0 = a < b, y1 = a == b, y2 = a > b (exactly one is high).
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       y0,
  output logic       y1,
  output logic       y2
);

  // Pure combinational relations; unsigned by construction of logic vectors.
  always_comb begin
    y0 = (a < b);
    y1 = (a == b);
    y2 = (a > b);
  end

endmodule
`default_nettype wire

// File: rtl/frame_trend_stats.sv
`default_nettype none
// ============================================================================
//  Module      : frame_trend_stats
//  Description : Groups valid-qualified 4-bit samples into frames of
//                FRAME_LEN samples and reports max, min and up/down/flat step
//                counts per frame with a one-cycle frame_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_trend_stats
  import frame_trend_stats_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [CNT_W-1:0]  up_cnt,
  output logic [CNT_W-1:0]  down_cnt,
  output logic [CNT_W-1:0]  flat_cnt,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t              state;
  state_t              state_next;
  logic                last_sample;

  logic [CNT_W-1:0]    idx;
  logic [DATA_W-1:0]   prev;
  logic [DATA_W-1:0]   run_max;
  logic [DATA_W-1:0]   run_min;
  logic [CNT_W-1:0]    run_up;
  logic [CNT_W-1:0]    run_down;
  logic [CNT_W-1:0]    run_flat;

  logic                step_lt;
  logic                step_eq;
  logic                step_gt;

  logic [DATA_W-1:0]   nxt_max;
  logic [DATA_W-1:0]   nxt_min;
  logic [CNT_W-1:0]    nxt_up;
  logic [CNT_W-1:0]    nxt_down;
  logic [CNT_W-1:0]    nxt_flat;

  // Step direction of the incoming sample relative to the previous one.
  comparator_4 u_step_cmp (
    .a  (data_in),
    .b  (prev),
    .y0 (step_lt),
    .y1 (step_eq),
    .y2 (step_gt)
  );

  // Running values including the current sample (used on every ST_ACC accept).
  always_comb begin
    nxt_max  = (data_in > run_max) ? data_in : run_max;
    nxt_min  = (data_in < run_min) ? data_in : run_min;
    nxt_up   = run_up   + CNT_W'(step_gt);
    nxt_down = run_down + CNT_W'(step_lt);
    nxt_flat = run_flat + CNT_W'(step_eq);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FIRST;
    else        state <= state_next;
  end

  // Next-state logic; flags the sample that closes the frame.
  always_comb begin
    state_next  = state;
    last_sample = 1'b0;
    case (state)
      ST_FIRST: begin
        if (data_valid) state_next = ST_ACC;
      end
      ST_ACC: begin
        if (data_valid && (idx == LAST_IDX)) begin
          last_sample = 1'b1;
          state_next  = ST_FIRST;
        end
      end
      default: state_next = ST_FIRST;
    endcase
  end

  // Running accumulators, sample index and previous-sample register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      prev     <= '0;
      run_max  <= '0;
      run_min  <= '0;
      run_up   <= '0;
      run_down <= '0;
      run_flat <= '0;
    end else if (data_valid) begin
      if (state == ST_FIRST) begin
        // First sample seeds max/min/prev and never counts as a step.
        idx      <= CNT_W'(1);
        prev     <= data_in;
        run_max  <= data_in;
        run_min  <= data_in;
        run_up   <= '0;
        run_down <= '0;
        run_flat <= '0;
      end else begin
        idx      <= last_sample ? '0 : idx + CNT_W'(1);
        prev     <= data_in;
        run_max  <= nxt_max;
        run_min  <= nxt_min;
        run_up   <= nxt_up;
        run_down <= nxt_down;
        run_flat <= nxt_flat;
      end
    end
  end

  // Output registers: capture the closed frame and pulse frame_done once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_out    <= '0;
      min_out    <= '0;
      up_cnt     <= '0;
      down_cnt   <= '0;
      flat_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_sample;
      if (last_sample) begin
        max_out  <= nxt_max;
        min_out  <= nxt_min;
        up_cnt   <= nxt_up;
        down_cnt <= nxt_down;
        flat_cnt <= nxt_flat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_trend_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_trend_stats
//  Description : Scoreboard bench for frame_trend_stats. Stimulus pushes the
//                hand-computed frame result; a monitor pops and compares it
//                whenever frame_done is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_trend_stats;

  localparam int FL = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    data_in;
  logic          data_valid;
  logic [3:0]    max_out;
  logic [3:0]    min_out;
  logic [CW-1:0] up_cnt;
  logic [CW-1:0] down_cnt;
  logic [CW-1:0] flat_cnt;
  logic          frame_done;

  typedef struct {
    int mx;
    int mn;
    int up;
    int dn;
    int fl;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  frame_trend_stats #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .max_out    (max_out),
    .min_out    (min_out),
    .up_cnt     (up_cnt),
    .down_cnt   (down_cnt),
    .flat_cnt   (flat_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every frame_done must match the oldest expected frame result.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("max_out", int'(max_out), e.mx);
        chk("min_out", int'(min_out), e.mn);
        chk("up_cnt", int'(up_cnt), e.up);
        chk("down_cnt", int'(down_cnt), e.dn);
        chk("flat_cnt", int'(flat_cnt), e.fl);
      end
    end
  end

  task automatic send(input int v);
    data_in    = 4'(v);
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send a whole frame; optional gaps of 1..3 idle cycles between samples.
  task automatic send_frame(input int s[FL], input int mx, input int mn,
                            input int up, input int dn, input int fl,
                            input bit gaps);
    exp_t e;
    for (int i = 0; i < FL; i++) begin
      send(s[i]);
      if (i == FL - 1) begin
        e.mx = mx; e.mn = mn; e.up = up; e.dn = dn; e.fl = fl; e.cyc = cyc;
        q.push_back(e);
      end else if (gaps) begin
        idle(int'($urandom_range(1, 3)));
      end
    end
  endtask

  task automatic chk_outputs(input string tag, input int mx, input int mn,
                             input int up, input int dn, input int fl, input int fd);
    chk({tag, "_max"},  int'(max_out),    mx);
    chk({tag, "_min"},  int'(min_out),    mn);
    chk({tag, "_up"},   int'(up_cnt),     up);
    chk({tag, "_down"}, int'(down_cnt),   dn);
    chk({tag, "_flat"}, int'(flat_cnt),   fl);
    chk({tag, "_done"}, int'(frame_done), fd);
  endtask

  initial begin
    int f1[FL]  = '{3, 5, 5, 2, 9, 9, 1, 4};
    int f7[FL]  = '{7, 7, 7, 7, 7, 7, 7, 7};
    int fa[FL]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int fx[FL]  = '{15, 0, 15, 0, 15, 0, 15, 0};
    int fr[FL]  = '{6, 2, 2, 10, 12, 3, 3, 14};
    int wait_n;

    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk_outputs("reset", 0, 0, 0, 0, 0, 0);

    // Basic frame, consecutive samples.
    send_frame(f1, 9, 1, 3, 2, 2, 1'b0);
    idle(3);

    // Same frame with random idle gaps.
    send_frame(f1, 9, 1, 3, 2, 2, 1'b1);
    idle(3);

    // Constant frame then ascending frame back-to-back.
    send_frame(f7, 7, 7, 0, 0, 7, 1'b0);
    send_frame(fa, 7, 0, 7, 0, 0, 1'b0);
    idle(3);

    // Extremes.
    send_frame(fx, 15, 0, 3, 4, 0, 1'b0);
    idle(3);

    // Mid-frame reset after four samples discards the partial frame.
    for (int i = 0; i < 4; i++) send(f1[i]);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_outputs("midreset", 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("midreset_no_done", int'(frame_done), 0);

    // Fresh frame after reset.
    send_frame(fr, 14, 2, 3, 2, 2, 1'b0);
    idle(3);

    // Hold: five samples of a new frame leave outputs untouched.
    for (int i = 0; i < 5; i++) send(fa[i]);
    chk_outputs("hold", 14, 2, 3, 2, 2, 0);
    // Close that frame: 0..4 then 7,7,7 -> up 5, flat 2.
    begin
      exp_t e;
      send(7);
      send(7);
      send(7);
      e.mx = 7; e.mn = 0; e.up = 5; e.dn = 0; e.fl = 2; e.cyc = cyc;
      q.push_back(e);
    end

    // Bounded wait for the scoreboard to drain.
    wait_n = 0;
    while (q.size() != 0 && wait_n < 20) begin
      idle(1);
      wait_n++;
    end
    chk("scoreboard_drained", q.size(), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
